fe_pipe_regs: RTL and testbench
===============================

# fe_pipe_regs

Pipeline front-end state block for the 5-stage MIPS datapath: PC register, IF/ID register, and ID/EX control register. It executes the stall, flush and redirect commands issued by the hazard detection unit, so it is the receiving end of that unit's PCWrite / IF_ID_Write / ID_EX_Flush / IF_Flush interface. It also tracks front-end status in a small FSM and, optionally, counts stall and flush cycles.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- CTRL_W, 9, width of the ID-stage control bundle carried into ID/EX
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- rst_n  in  1  asynchronous, active-low reset
- pc_write  in  1  1 = PC may update; 0 = hold PC
- if_id_write  in  1  1 = IF/ID may load; 0 = hold IF/ID
- id_ex_flush  in  1  1 = insert bubble into ID/EX
- if_flush  in  1  1 = squash the instruction entering IF/ID
- id_jump  in  1  ID holds a jump
- id_take_branch  in  1  ID holds a resolved taken branch (beq equal / bne not-equal)
- jump_target  in  32  jump destination
- branch_target  in  32  branch destination
- imem_instr  in  32  instruction at `pc`, asynchronous-read instruction memory
- id_ctrl  in  CTRL_W  decoder control bundle for the instruction in ID
- pc  out  32  current fetch address
- if_id_instr  out  32  instruction in ID
- if_id_pc4  out  32  PC+4 of the instruction in ID
- if_id_valid  out  1  ID holds a real instruction
- id_ex_ctrl  out  CTRL_W  control bundle in EX
- id_ex_valid  out  1  EX holds a real instruction
- fe_state  out  2  front-end FSM state
- stall_cnt  out  CNT_W  stall-cycle count (see Configuration)
- flush_cnt  out  CNT_W  flush-event count (see Configuration)

## Operation
- Next PC when pc_write=1, in priority order: id_jump → jump_target; else id_take_branch → branch_target; else pc+4. The sum wraps modulo 2^32. Target bits [1:0] are forced to 0.
- When pc_write=0, PC holds. Any redirect in that cycle is ignored; the held ID instruction re-presents it on a later cycle.
- IF/ID update, in priority order:
  - if_flush=1: load the bubble. instr=32'h0 (sll nop), pc4=0, valid=0.
  - else if if_id_write=1: load instr=imem_instr, pc4=pc+4, valid=1.
  - else: hold.
- if_flush together with if_id_write=0 never comes from the hazard unit. If it occurs, the flush wins.
- ID/EX update happens every cycle:
  - id_ex_flush=1: ctrl=0, valid=0.
  - otherwise: ctrl=id_ctrl, valid=if_id_valid.
- FSM (fe_state) records the action taken on the last edge:
  - BOOT=2'b00, RUN=2'b01, STALL=2'b10, FLUSH=2'b11.
  - On every edge, evaluate in order: pc_write=0 → STALL; else if_flush=1 → FLUSH; else → RUN.
  - Reset forces BOOT. BOOT is left on the first edge, following the same rules.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- Reset values: pc=PC_RESET; if_id_instr=0; if_id_pc4=0; if_id_valid=0; id_ex_ctrl=0; id_ex_valid=0; fe_state=BOOT; stall_cnt=0; flush_cnt=0.
- Reset asserted mid-operation clears all state immediately (asynchronously). The first fetch after release is from PC_RESET.
- Redirect latency: taken branch or jump sampled at edge n gives pc=target and an IF/ID bubble after edge n; the target instruction is in IF/ID after edge n+1. Penalty is one bubble.
- Load-use stall: pc_write=if_id_write=0 with id_ex_flush=1 for one edge gives PC and IF/ID held and id_ex_valid=0 for one cycle. The instruction resumes on the next edge.
- Multi-cycle stalls hold PC and IF/ID indefinitely with no drift.

## Configuration
- FE_PERF_CNT_EN defined:
  - stall_cnt increments on each edge with pc_write=0.
  - flush_cnt increments on each edge with if_flush=1 or id_ex_flush=1 (by 1, not 2, when both are high).
  - Both counters saturate at 2^CNT_W−1 and clear only on reset.
- FE_PERF_CNT_EN undefined: counters are not instantiated, and stall_cnt and flush_cnt are constant 0.

## Test plan
- Reset, then release with PC_RESET=0 and pc_write=if_id_write=1 for 3 edges: pc=0,4,8,12; if_id_pc4=12 with if_id_valid=1; fe_state BOOT→RUN.
- Load-use: one edge with pc_write=if_id_write=0 and id_ex_flush=1, pc=0x10: pc stays 0x10, IF/ID unchanged, id_ex_ctrl=0, id_ex_valid=0, fe_state=STALL. Next normal edge gives pc=0x14.
- Taken branch at pc=0x20 with branch_target=0x103 and if_flush=1: pc=0x100, if_id_instr=0, if_id_valid=0, fe_state=FLUSH. The next edge loads the instruction from 0x100.
- Jump and branch asserted together, jump_target=0x40, branch_target=0x80: pc=0x40. Same inputs with pc_write=0: pc holds.
- pc=0xFFFF_FFFC, no redirect: pc wraps to 0 and if_id_pc4=0. Assert rst_n low mid-stall: all outputs return to reset values without a clock edge.
- With FE_PERF_CNT_EN, CNT_W=2: 5 stall edges give stall_cnt=3 (saturated); one edge with both flushes gives flush_cnt +1. Without the macro, both counters read 0.

Source files
------------

// File: rtl/fe_pipe_regs.sv
// Front-end state for the 5-stage MIPS pipe: PC, IF/ID, ID/EX control, status FSM, optional FE_PERF_CNT_EN counters.
// Latency: every output is registered; a redirect sampled at edge n shows pc=target after edge n.
// Backpressure: pc_write/if_id_write low hold PC and IF/ID indefinitely; id_ex_flush/if_flush insert bubbles.
module fe_pipe_regs #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CTRL_W   = 9,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              id_ex_flush,
    input  logic              if_flush,
    input  logic              id_jump,
    input  logic              id_take_branch,
    input  logic [31:0]       jump_target,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_valid,
    output logic [1:0]        fe_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FLUSH = 2'b11
    } fe_state_t;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       pc_plus4;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [31:0]       if_id_pc4_q, if_id_pc4_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
    logic              id_ex_valid_q, id_ex_valid_d;
    fe_state_t         state_q, state_d;

    assign pc_plus4 = pc_q + 32'd4;

    // A redirect seen while PC is held is dropped; the held ID instruction re-issues it later.
    always_comb begin
        pc_d = pc_q;
        if (pc_write) begin
            if (id_jump)
                pc_d = {jump_target[31:2], 2'b00};
            else if (id_take_branch)
                pc_d = {branch_target[31:2], 2'b00};
            else
                pc_d = pc_plus4;
        end
    end

    always_comb begin
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (if_flush) begin
            if_id_instr_d = 32'h0;
            if_id_pc4_d   = 32'h0;
            if_id_valid_d = 1'b0;
        end else if (if_id_write) begin
            if_id_instr_d = imem_instr;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
        end
    end

    always_comb begin
        id_ex_ctrl_d  = id_ctrl;
        id_ex_valid_d = if_id_valid_q;
        if (id_ex_flush) begin
            id_ex_ctrl_d  = '0;
            id_ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = RUN;
        if (!pc_write)
            state_d = STALL;
        else if (if_flush)
            state_d = FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_RESET;
            if_id_instr_q <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            id_ex_ctrl_q  <= '0;
            id_ex_valid_q <= 1'b0;
            state_q       <= BOOT;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_ctrl_q  <= id_ex_ctrl_d;
            id_ex_valid_q <= id_ex_valid_d;
            state_q       <= state_d;
        end
    end

`ifdef FE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; a cycle with both flushes counts once.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((if_flush || id_ex_flush) && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign id_ex_ctrl  = id_ex_ctrl_q;
    assign id_ex_valid = id_ex_valid_q;
    assign fe_state    = state_q;

endmodule

// File: tb/tb_fe_pipe_regs.sv
// Bench for fe_pipe_regs: directed steps from the front-end scenarios, then random traffic against a reference model.
module tb_fe_pipe_regs;

    localparam int CTRL_W = 9;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pc_write = 1'b1, if_id_write = 1'b1, id_ex_flush = 1'b0, if_flush = 1'b0;
    logic              id_jump = 1'b0, id_take_branch = 1'b0;
    logic [31:0]       jump_target = '0, branch_target = '0;
    logic [31:0]       imem_instr;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [31:0]       pc, if_id_instr, if_id_pc4;
    logic              if_id_valid, id_ex_valid;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [1:0]        fe_state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int errs = 0;
    int checks = 0;

    // Reference state
    logic [31:0]       m_pc, m_ii, m_ip4;
    logic              m_iv, m_ev;
    logic [CTRL_W-1:0] m_ctrl;
    logic [1:0]        m_st;
    int                m_sc, m_fc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_instr = mem(pc);

    fe_pipe_regs #(.PC_RESET(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_flush(id_ex_flush), .if_flush(if_flush),
        .id_jump(id_jump), .id_take_branch(id_take_branch),
        .jump_target(jump_target), .branch_target(branch_target),
        .imem_instr(imem_instr), .id_ctrl(id_ctrl),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl), .id_ex_valid(id_ex_valid),
        .fe_state(fe_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ii = 32'h0; m_ip4 = 32'h0; m_iv = 1'b0;
        m_ctrl = '0; m_ev = 1'b0; m_st = 2'b00; m_sc = 0; m_fc = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".ifid_instr"}, if_id_instr, m_ii);
        chk({tag, ".ifid_pc4"}, if_id_pc4, m_ip4);
        chk({tag, ".ifid_valid"}, {31'b0, if_id_valid}, {31'b0, m_iv});
        chk({tag, ".idex_ctrl"}, {23'b0, id_ex_ctrl}, {23'b0, m_ctrl});
        chk({tag, ".idex_valid"}, {31'b0, id_ex_valid}, {31'b0, m_ev});
        chk({tag, ".state"}, {30'b0, fe_state}, {30'b0, m_st});
`ifdef FE_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, {30'b0, stall_cnt}, m_sc);
        chk({tag, ".flush_cnt"}, {30'b0, flush_cnt}, m_fc);
`else
        chk({tag, ".stall_cnt"}, {30'b0, stall_cnt}, 32'h0);
        chk({tag, ".flush_cnt"}, {30'b0, flush_cnt}, 32'h0);
`endif
    endtask

    // One clock edge with the currently driven inputs; model advances from the rules, then all outputs compared.
    task automatic step(input string tag);
        logic [31:0] npc;
        int          sat;
        sat = (1 << CNT_W) - 1;
        if (!pc_write)           npc = m_pc;
        else if (id_jump)        npc = jump_target & ~32'd3;
        else if (id_take_branch) npc = branch_target & ~32'd3;
        else                     npc = m_pc + 32'd4;
        m_ctrl = id_ex_flush ? '0 : id_ctrl;
        m_ev   = id_ex_flush ? 1'b0 : m_iv;
        if (if_flush) begin
            m_ii = 32'h0; m_ip4 = 32'h0; m_iv = 1'b0;
        end else if (if_id_write) begin
            m_ii = mem(m_pc); m_ip4 = m_pc + 32'd4; m_iv = 1'b1;
        end
        m_st = !pc_write ? 2'b10 : (if_flush ? 2'b11 : 2'b01);
        if (!pc_write && m_sc < sat) m_sc++;
        if ((if_flush || id_ex_flush) && m_fc < sat) m_fc++;
        m_pc = npc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic normal();
        pc_write = 1'b1; if_id_write = 1'b1; id_ex_flush = 1'b0; if_flush = 1'b0;
        id_jump = 1'b0; id_take_branch = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Boot sequence: 0,4,8,12
        normal();
        id_ctrl = 9'h1A5;
        step("boot1");
        chk("boot1.state_lit", {30'b0, fe_state}, 32'd1);
        step("boot2");
        step("boot3");
        chk("boot3.pc_lit", pc, 32'd12);
        chk("boot3.pc4_lit", if_id_pc4, 32'd12);
        step("to10");

        // Load-use stall at 0x10
        pc_write = 1'b0; if_id_write = 1'b0; id_ex_flush = 1'b1;
        step("loaduse");
        chk("loaduse.pc_lit", pc, 32'h10);
        chk("loaduse.state_lit", {30'b0, fe_state}, 32'd2);
        normal();
        step("resume");
        chk("resume.pc_lit", pc, 32'h14);
        step("to18"); step("to1c"); step("to20");

        // Taken branch at 0x20 to unaligned 0x103
        id_take_branch = 1'b1; branch_target = 32'h103; if_flush = 1'b1;
        step("branch");
        chk("branch.pc_lit", pc, 32'h100);
        chk("branch.valid_lit", {31'b0, if_id_valid}, 32'd0);
        normal();
        step("target");
        chk("target.instr_lit", if_id_instr, mem(32'h100));

        // Jump beats branch; held when pc_write=0
        id_jump = 1'b1; id_take_branch = 1'b1; jump_target = 32'h40; branch_target = 32'h80;
        step("jmpbr");
        chk("jmpbr.pc_lit", pc, 32'h40);
        pc_write = 1'b0;
        step("jmpbr_hold");
        chk("jmpbr_hold.pc_lit", pc, 32'h40);

        // Wrap past 0xFFFF_FFFC
        normal();
        id_jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("to_top");
        normal();
        step("wrap");
        chk("wrap.pc_lit", pc, 32'h0);
        chk("wrap.pc4_lit", if_id_pc4, 32'h0);

        // Counter saturation and dual flush
        pc_write = 1'b0; if_id_write = 1'b0;
        for (int i = 0; i < 5; i++) step("stall5");
        normal();
        if_flush = 1'b1; id_ex_flush = 1'b1;
        step("dualflush");

        // Asynchronous reset mid-stall
        normal();
        pc_write = 1'b0; if_id_write = 1'b0;
        step("prestall");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst_n = 1'b1;
        normal();
        step("post_rst");
        chk("post_rst.pc_lit", pc, 32'h4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pc_write       = ($urandom_range(0, 4) != 0);
            if_id_write    = pc_write ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            id_ex_flush    = ($urandom_range(0, 5) == 0);
            if_flush       = ($urandom_range(0, 5) == 0);
            id_jump        = ($urandom_range(0, 7) == 0);
            id_take_branch = ($urandom_range(0, 5) == 0);
            jump_target    = $urandom;
            branch_target  = $urandom;
            id_ctrl        = CTRL_W'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
